// File: rtl/axis_bram_reader.sv
`default_nettype none
// ============================================================================
// Module   : axis_bram_reader
// Brief    : Reads a contiguous (wrapping) range of words from a BRAM port
//            with 1-cycle read latency and emits them as an AXI-Stream master.
//            A 2-entry output buffer sustains one beat per cycle.
// Options  : define AXIS_BRAM_READER_STALL_CNT_EN to add the stall_cnt output
//            (saturating count of cycles with tvalid=1 and tready=0).
// Revision : 1.0 - initial release
// ============================================================================
module axis_bram_reader #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] index_cntl,
   input  logic [ADDR_W-1:0] size_cntl,
   output logic              bram_en,
   output logic [ADDR_W-1:0] bram_index,
   input  logic [DATA_W-1:0] bram_dout,
   output logic [DATA_W-1:0] stream_out_tdata,
   output logic              stream_out_tvalid,
   input  logic              stream_out_tready,
   output logic              stream_out_tlast,
   output logic              busy,
`ifdef AXIS_BRAM_READER_STALL_CNT_EN
   output logic [15:0]       stall_cnt,
`endif
   output logic              done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W-1:0]   last_q;
   logic [ADDR_W:0]     issue_cnt_q;   // one bit wider so a full 2^ADDR_W range terminates
   logic [ADDR_W-1:0]   beat_cnt_q;
   logic                busy_q;
   logic                done_q;

   logic [DATA_W-1:0]   buf_q [2];
   logic                rd_ptr_q;
   logic                wr_ptr_q;
   logic [1:0]          count_q;
   logic                inflight_q;    // a read was issued last cycle; data arrives now

   logic                pop_w;
   logic [1:0]          slots_used_w;
   logic                issue_w;

   // Output side of the buffer; a pop this cycle frees a slot for a new read
   assign stream_out_tvalid = (count_q != 2'd0);
   assign stream_out_tdata  = buf_q[rd_ptr_q];
   assign stream_out_tlast  = stream_out_tvalid && (beat_cnt_q == last_q);
   assign pop_w             = stream_out_tvalid && stream_out_tready;

   // Buffered words plus the word in flight, minus the one leaving this cycle.
   // count_q <= 2 and inflight adds at most 1, so 2 bits never overflow.
   assign slots_used_w = count_q + {1'b0, inflight_q} - {1'b0, pop_w};
   assign issue_w      = (state_q == ST_RUN) &&
                         (issue_cnt_q <= {1'b0, last_q}) &&
                         (slots_used_w < 2'd2);

   assign bram_en    = issue_w;
   assign bram_index = base_q + issue_cnt_q[ADDR_W-1:0];   // wraps past top address
   assign busy       = busy_q;
   assign done       = done_q;

   // Control FSM: latch the request, count issued reads and delivered beats
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         last_q      <= '0;
         issue_cnt_q <= '0;
         beat_cnt_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  base_q      <= index_cntl;
                  last_q      <= size_cntl;
                  issue_cnt_q <= '0;
                  beat_cnt_q  <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (issue_w) begin
                  issue_cnt_q <= issue_cnt_q + (ADDR_W+1)'(1);
               end
               if (pop_w) begin
                  beat_cnt_q <= beat_cnt_q + ADDR_W'(1);
                  if (stream_out_tlast) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Two-entry buffer: capture read data one cycle after issue, pop on handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            buf_q[i] <= '0;
         end
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         inflight_q <= 1'b0;
      end else begin
         if (inflight_q) begin
            buf_q[wr_ptr_q] <= bram_dout;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_w) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q    <= count_q + {1'b0, inflight_q} - {1'b0, pop_w};
         inflight_q <= issue_w;
      end
   end

`ifdef AXIS_BRAM_READER_STALL_CNT_EN
   logic [15:0] stall_cnt_q;
   assign stall_cnt = stall_cnt_q;

   // Saturating count of back-pressured valid cycles, cleared per transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 16'd0;
      end else if ((state_q == ST_IDLE) && start) begin
         stall_cnt_q <= 16'd0;
      end else if (stream_out_tvalid && !stream_out_tready && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_bram_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_bram_reader
// Brief    : Self-checking bench for axis_bram_reader with a BRAM model and a
//            scoreboard of expected beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_bram_reader;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] index_cntl;
   logic [ADDR_W-1:0] size_cntl;
   logic              bram_en;
   logic [ADDR_W-1:0] bram_index;
   logic [DATA_W-1:0] bram_dout = '0;
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic              busy;
   logic              done;
`ifdef AXIS_BRAM_READER_STALL_CNT_EN
   logic [15:0]       stall_cnt;
`endif

   axis_bram_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .index_cntl        (index_cntl),
      .size_cntl         (size_cntl),
      .bram_en           (bram_en),
      .bram_index        (bram_index),
      .bram_dout         (bram_dout),
      .stream_out_tdata  (tdata),
      .stream_out_tvalid (tvalid),
      .stream_out_tready (tready),
      .stream_out_tlast  (tlast),
      .busy              (busy),
`ifdef AXIS_BRAM_READER_STALL_CNT_EN
      .stall_cnt         (stall_cnt),
`endif
      .done              (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // BRAM model, 1-cycle read latency
   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (bram_en) bram_dout <= mem[bram_index];
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard and monitor statistics
   logic [DATA_W-1:0] exp_d [$];
   logic              exp_l [$];
   int                idx_log [$];
   int beats = 0, en_cnt = 0, done_cnt = 0, stall_tb = 0, last_hs_cyc = -10;
   int occ = 0, infl = 0;
   logic              prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data  = '0;
   logic              prev_last  = 1'b0;

   always @(negedge clk) begin
      int pop;
      if (rst) begin
         occ = 0; infl = 0; prev_stall = 1'b0;
      end else begin
         pop = (tvalid && tready) ? 1 : 0;
         if (bram_en) begin
            en_cnt++;
            idx_log.push_back(int'(bram_index));
            chk("no_overflow", (occ + infl - pop) < 2, 1);
         end
         if (prev_stall) begin
            chk("stall_valid", tvalid, 1);
            chk("stall_data", tdata, prev_data);
            chk("stall_last", tlast, prev_last);
         end
         if (pop != 0) begin
            chk("beat_expected", exp_d.size() != 0, 1);
            if (exp_d.size() != 0) begin
               chk("beat_data", tdata, exp_d.pop_front());
               chk("beat_last", tlast, exp_l.pop_front());
            end
            beats++;
            if (tlast) last_hs_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            chk("done_timing", cyc, last_hs_cyc + 1);
         end
         if (tvalid && !tready) stall_tb++;
         prev_stall = tvalid && !tready;
         prev_data  = tdata;
         prev_last  = tlast;
         occ  = occ + infl - pop;
         infl = bram_en ? 1 : 0;
      end
   end

   task automatic clear_stats();
      beats = 0; en_cnt = 0; done_cnt = 0; stall_tb = 0;
      idx_log.delete();
   endtask

   // Drive a 1-cycle start and queue the expected beats; t0 is the start cycle
   task automatic do_start(input int idx, input int sz, output int t0);
      @(posedge clk); #1;
      start = 1'b1; index_cntl = ADDR_W'(idx); size_cntl = ADDR_W'(sz);
      t0 = cyc;
      for (int k = 0; k <= sz; k++) begin
         exp_d.push_back(mem[(idx + k) % DEPTH]);
         exp_l.push_back(k == sz);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int dcyc);
      logic got = 1'b0;
      dcyc = -1;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; dcyc = cyc; break; end
      end
      chk("done_seen", got, 1);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_bram_en"}, bram_en, 0);
      chk({pfx, "_bram_index"}, bram_index, 0);
      chk({pfx, "_tvalid"}, tvalid, 0);
      chk({pfx, "_tdata"}, tdata, 0);
      chk({pfx, "_tlast"}, tlast, 0);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_done"}, done, 0);
   endtask

   initial begin
      int t0, dcyc, dc, bsave;
      logic got;
      rst = 1'b1; start = 1'b0; index_cntl = '0; size_cntl = '0; tready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // 16 back-to-back beats with latency and throughput check
      clear_stats();
      tready = 1'b1;
      @(posedge clk); #1;
      start = 1'b1; index_cntl = '0; size_cntl = ADDR_W'(15); t0 = cyc;
      for (int k = 0; k <= 15; k++) begin
         exp_d.push_back(mem[k]);
         exp_l.push_back(k == 15);
      end
      @(negedge clk);
      chk("lat_c0_en", bram_en, 0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("lat_c1_en", bram_en, 1);
      chk("lat_c1_busy", busy, 1);
      @(negedge clk);
      chk("lat_c2_valid", tvalid, 0);
      @(negedge clk);
      chk("lat_c3_valid", tvalid, 1);
      wait_done(100, dcyc);
      chk("t1_done_cycle", dcyc, t0 + 19);
      chk("t1_beats", beats, 16);

      // Single beat
      clear_stats();
      do_start(4, 0, t0);
      wait_done(50, dcyc);
      chk("t2_beats", beats, 1);
      chk("t2_en_cycles", en_cnt, 1);

      // Address wrap past the top
      clear_stats();
      do_start(510, 3, t0);
      wait_done(50, dcyc);
      chk("t3_idx_count", idx_log.size(), 4);
      for (int k = 0; k < 4 && k < idx_log.size(); k++)
         chk("t3_idx_seq", idx_log[k], (510 + k) % DEPTH);
      chk("t3_beats", beats, 4);

      // Back-pressure: toggling tready plus a 5-cycle hold low
      clear_stats();
      do_start(0, 7, t0);
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk); #1;
         tready = (k >= 6 && k < 11) ? 1'b0 : ((k % 2) == 0);
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
      chk("t4_done_seen", got, 1);
      chk("t4_beats", beats, 8);
      chk("t4_sb_empty", exp_d.size(), 0);
      chk("t4_stalls_seen", stall_tb >= 5, 1);
`ifdef AXIS_BRAM_READER_STALL_CNT_EN
      chk("t4_stall_cnt", stall_cnt, stall_tb);
`endif
      @(posedge clk); #1;
      tready = 1'b1;

      // Start pulses during RUN and during DONE are ignored
      clear_stats();
      do_start(0, 5, t0);
      repeat (2) @(posedge clk); #1;
      start = 1'b1; index_cntl = ADDR_W'(100); size_cntl = ADDR_W'(3);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (t0 + 9 - cyc) @(posedge clk); #1;
      start = 1'b1;
      @(negedge clk);
      chk("t5_done_at_cycle", done, 1);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("t5_beats", beats, 6);
      chk("t5_en_cycles", en_cnt, 6);
      chk("t5_done_pulses", done_cnt, 1);
      chk("t5_idle_busy", busy, 0);
      chk("t5_idle_valid", tvalid, 0);

      // Reset mid-transfer aborts, then a fresh transfer
      clear_stats();
      do_start(0, 9, t0);
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (beats >= 3) break;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      dc = done_cnt;
      @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("midrst");
      exp_d.delete(); exp_l.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      bsave = beats;
      repeat (15) @(negedge clk);
      chk("t6_no_done", done_cnt, dc);
      chk("t6_no_beats", beats, bsave);
      clear_stats();
      do_start(0, 2, t0);
      wait_done(50, dcyc);
      chk("t6_fresh_beats", beats, 3);
      chk("t6_sb_empty", exp_d.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
